pq_cmd_sequencer: RTL and testbench

//  Initiator-side front end for the RegisterTree priority queue. Accepts ENQ/DEQ/REPLACE commands
//  on a valid/ready port. Drives one-cycle i_wrt/i_read pulses into the queue. Holds off further

---
 rtl/pq_cmd_sequencer_pkg.sv | 30 +++
 rtl/pq_cmd_sequencer_if.sv | 28 ++
 rtl/pq_cmd_sequencer.sv | 154 +++++++++++++++
 tb/tb_pq_cmd_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pq_cmd_sequencer_pkg.sv
// Shared types and helpers for the priority-queue command sequencer.
package pq_cmd_sequencer_pkg;

    // Command opcodes; encoding 2'd3 is reserved and always rejected.
    typedef enum logic [1:0] {
        OP_ENQ = 2'd0,
        OP_DEQ = 2'd1,
        OP_REP = 2'd2
    } op_e;

    // Response status.
    typedef enum logic {
        ST_OK     = 1'b0,
        ST_REJECT = 1'b1
    } status_e;

    // Sequencer FSM encoding; also the encoding seen on the o_state debug port.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_SETTLE = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    // Bits needed to hold the unsigned value n (at least 1 bit).
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pq_cmd_sequencer_if.sv
// Command/response port of the sequencer.
// Both channels use strict valid/ready: a transfer happens on the rising clock edge
// where valid && ready; the sender holds valid and its payload stable until then,
// and valid never waits on ready.
interface pq_cmd_sequencer_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  i_cmd_valid;
    logic                  o_cmd_ready;
    logic [1:0]            i_cmd_op;
    logic [DATA_WIDTH-1:0] i_cmd_data;
    logic                  o_rsp_valid;
    logic                  i_rsp_ready;
    logic [DATA_WIDTH-1:0] o_rsp_data;
    logic                  o_rsp_status;

    // Scheduler side: issues commands, consumes responses.
    modport master (
        output i_cmd_valid, i_cmd_op, i_cmd_data, i_rsp_ready,
        input  o_cmd_ready, o_rsp_valid, o_rsp_data, o_rsp_status
    );

    // Sequencer side.
    modport slave (
        input  i_cmd_valid, i_cmd_op, i_cmd_data, i_rsp_ready,
        output o_cmd_ready, o_rsp_valid, o_rsp_data, o_rsp_status
    );
endinterface

// File: rtl/pq_cmd_sequencer.sv
// Initiator-side front end for a RegisterTree priority queue: accepts one
// ENQ/DEQ/REP command at a time, pulses the queue for one cycle, waits out the
// queue's settle latency and returns a response with the popped value.
module pq_cmd_sequencer
    import pq_cmd_sequencer_pkg::*;
#(
    parameter int   DATA_WIDTH = 16,
    parameter int   QUEUE_SIZE = 15,
    parameter logic ENQ_ENA    = 1'b1,
    parameter int   ENQ_LAT    = $clog2(QUEUE_SIZE),
    parameter int   DEQ_LAT    = 2,
    localparam int  CNT_WIDTH  = cnt_w(QUEUE_SIZE)
) (
    input  logic                  i_CLK,
    input  logic                  i_RSTn,
    pq_cmd_sequencer_if.slave     cmd_if,
    output logic                  o_pq_wrt,
    output logic                  o_pq_read,
    output logic [DATA_WIDTH-1:0] o_pq_data,
    input  logic                  i_pq_full,
    input  logic                  i_pq_empty,
    input  logic [DATA_WIDTH-1:0] i_pq_data,
    output logic [CNT_WIDTH-1:0]  o_count,
    output logic [1:0]            o_state
);

    localparam logic [1:0] IDLE   = 2'(S_IDLE);
    localparam logic [1:0] ISSUE  = 2'(S_ISSUE);
    localparam logic [1:0] SETTLE = 2'(S_SETTLE);
    localparam logic [1:0] RESP   = 2'(S_RESP);

    localparam int MAX_LAT = (ENQ_LAT > DEQ_LAT) ? ENQ_LAT : DEQ_LAT;
    localparam int SET_W   = cnt_w(MAX_LAT);
    localparam logic [SET_W-1:0]     ENQ_LOAD = SET_W'(ENQ_LAT - 1);
    localparam logic [SET_W-1:0]     DEQ_LOAD = SET_W'(DEQ_LAT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(QUEUE_SIZE);

    logic [1:0]            r_state;
    logic [1:0]            r_op;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_was_empty;
    logic [DATA_WIDTH-1:0] r_top;
    logic [SET_W-1:0]      r_settle;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_status;
    logic [CNT_WIDTH-1:0]  r_count;

    logic                  w_accept;
    logic                  w_reject;
    logic                  w_in_issue;

    assign w_accept   = (r_state == IDLE) && cmd_if.i_cmd_valid;
    assign w_in_issue = (r_state == ISSUE);

    // Reject decision on the command being presented, checked in priority order.
    always_comb begin
        w_reject = 1'b0;
        if (cmd_if.i_cmd_op == 2'd3) begin
            w_reject = 1'b1;
        end else if (cmd_if.i_cmd_op == OP_ENQ) begin
            w_reject = i_pq_full || !ENQ_ENA;
        end else if (cmd_if.i_cmd_op == OP_DEQ) begin
            w_reject = i_pq_empty;
        end
    end

    // Main FSM: latch the command and queue snapshot at accept, pulse, settle, respond.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            r_state      <= IDLE;
            r_op         <= 2'd0;
            r_data       <= '0;
            r_was_empty  <= 1'b0;
            r_top        <= '0;
            r_settle     <= '0;
            r_rsp_data   <= '0;
            r_rsp_status <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op        <= cmd_if.i_cmd_op;
                        r_data      <= cmd_if.i_cmd_data;
                        r_was_empty <= i_pq_empty;
                        r_top       <= i_pq_data;
                        if (w_reject) begin
                            r_rsp_data   <= '0;
                            r_rsp_status <= ST_REJECT;
                            r_state      <= RESP;
                        end else begin
                            r_state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    // The popped value is the top sampled at accept; a push-only REP returns 0.
                    r_settle     <= (r_op == OP_ENQ) ? ENQ_LOAD : DEQ_LOAD;
                    r_rsp_status <= ST_OK;
                    if ((r_op == OP_DEQ) || ((r_op == OP_REP) && !r_was_empty)) begin
                        r_rsp_data <= r_top;
                    end else begin
                        r_rsp_data <= '0;
                    end
                    r_state <= SETTLE;
                end
                SETTLE: begin
                    if (r_settle == '0) begin
                        r_state <= RESP;
                    end else begin
                        r_settle <= r_settle - 1'b1;
                    end
                end
                RESP: begin
                    if (cmd_if.i_rsp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Shadow occupancy, updated in the pulse cycle and clamped to [0, QUEUE_SIZE].
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            r_count <= '0;
        end else if (w_in_issue) begin
            if ((r_op == OP_ENQ) || ((r_op == OP_REP) && r_was_empty)) begin
                if (r_count != CNT_MAX) begin
                    r_count <= r_count + 1'b1;
                end
            end else if (r_op == OP_DEQ) begin
                if (r_count != '0) begin
                    r_count <= r_count - 1'b1;
                end
            end
        end
    end

    // Queue pulses exist only in ISSUE; data bus is zero whenever no write is issued.
    always_comb begin
        o_pq_wrt  = w_in_issue && (r_op != OP_DEQ);
        o_pq_read = w_in_issue && (r_op != OP_ENQ);
        o_pq_data = (w_in_issue && (r_op != OP_DEQ)) ? r_data : '0;
    end

    assign cmd_if.o_cmd_ready  = (r_state == IDLE);
    assign cmd_if.o_rsp_valid  = (r_state == RESP);
    assign cmd_if.o_rsp_data   = r_rsp_data;
    assign cmd_if.o_rsp_status = r_rsp_status;
    assign o_count             = r_count;
    assign o_state             = r_state;

endmodule

// File: tb/tb_pq_cmd_sequencer.sv
// Directed bench for pq_cmd_sequencer with a behavioural max-priority queue attached.
module tb_pq_cmd_sequencer;
    import pq_cmd_sequencer_pkg::*;

    localparam int DW = 16;
    localparam int QS = 15;

    logic          i_CLK = 1'b0;
    logic          i_RSTn = 1'b0;
    logic          o_pq_wrt;
    logic          o_pq_read;
    logic [DW-1:0] o_pq_data;
    logic          pq_full = 1'b0;
    logic          pq_empty = 1'b1;
    logic [DW-1:0] pq_top = '0;
    logic [3:0]    o_count;
    logic [1:0]    o_state;

    int total = 0;
    int bad = 0;

    pq_cmd_sequencer_if #(.DATA_WIDTH(DW)) cmd_if ();

    pq_cmd_sequencer #(
        .DATA_WIDTH(DW), .QUEUE_SIZE(QS), .ENQ_ENA(1'b1), .ENQ_LAT(4), .DEQ_LAT(2)
    ) dut (
        .i_CLK(i_CLK), .i_RSTn(i_RSTn), .cmd_if(cmd_if),
        .o_pq_wrt(o_pq_wrt), .o_pq_read(o_pq_read), .o_pq_data(o_pq_data),
        .i_pq_full(pq_full), .i_pq_empty(pq_empty), .i_pq_data(pq_top),
        .o_count(o_count), .o_state(o_state)
    );

    // Clock.
    always #5 i_CLK = ~i_CLK;

    // Behavioural max-priority queue standing in for the RegisterTree.
    logic [DW-1:0] q[$];
    always @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            q.delete();
        end else if (o_pq_wrt && o_pq_read) begin
            if (q.size() == 0) q.push_back(o_pq_data);
            else q[0] = o_pq_data;
            q.rsort();
        end else if (o_pq_wrt) begin
            if (q.size() < QS) q.push_back(o_pq_data);
            q.rsort();
        end else if (o_pq_read) begin
            if (q.size() > 0) void'(q.pop_front());
        end
        pq_full  = (q.size() == QS);
        pq_empty = (q.size() == 0);
        pq_top   = (q.size() > 0) ? q[0] : '0;
    end

    // Pulse monitor, sampled on the falling edge.
    int            wrt_cnt = 0;
    int            read_cnt = 0;
    logic [DW-1:0] last_wrt_data = '0;
    always @(negedge i_CLK) begin
        if (o_pq_wrt) begin
            wrt_cnt++;
            last_wrt_data = o_pq_data;
        end
        if (o_pq_read) read_cnt++;
    end

    // Driver: present a command and return #1 after its accept edge.
    task automatic drive_cmd(input logic [1:0] op, input logic [DW-1:0] data);
        int n;
        @(negedge i_CLK);
        cmd_if.i_cmd_valid = 1'b1;
        cmd_if.i_cmd_op    = op;
        cmd_if.i_cmd_data  = data;
        n = 0;
        while (!cmd_if.o_cmd_ready && n < 100) begin
            @(negedge i_CLK);
            n++;
        end
        total++;
        if (n == 100) begin
            bad++;
            $display("FAIL accept_timeout: ready=%b required=1", cmd_if.o_cmd_ready);
        end
        @(posedge i_CLK);
        #1;
        cmd_if.i_cmd_valid = 1'b0;
    endtask

    // Cycles from the accept edge until o_rsp_valid is seen (1 = the cycle after accept).
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!cmd_if.o_rsp_valid && lat < 50) begin
            @(posedge i_CLK);
            #1;
            lat++;
        end
        total++;
        if (!cmd_if.o_rsp_valid) begin
            bad++;
            $display("FAIL rsp_timeout: rsp_valid=%b required=1", cmd_if.o_rsp_valid);
        end
    endtask

    task automatic ack_rsp();
        cmd_if.i_rsp_ready = 1'b1;
        @(posedge i_CLK);
        #1;
        cmd_if.i_rsp_ready = 1'b0;
    endtask

    // Full command round trip; reports latency, response and pulse counts.
    task automatic do_cmd(input logic [1:0] op, input logic [DW-1:0] data,
                          output int lat, output logic [DW-1:0] rd, output logic st,
                          output int dw, output int dr);
        int w0;
        int r0;
        w0 = wrt_cnt;
        r0 = read_cnt;
        drive_cmd(op, data);
        wait_rsp(lat);
        rd = cmd_if.o_rsp_data;
        st = cmd_if.o_rsp_status;
        dw = wrt_cnt - w0;
        dr = read_cnt - r0;
        ack_rsp();
    endtask

    task automatic test_reset();
        total++;
        if (cmd_if.o_cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got=%b exp=1", cmd_if.o_cmd_ready); end
        total++;
        if (cmd_if.o_rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got=%b exp=0", cmd_if.o_rsp_valid); end
        total++;
        if ({o_pq_wrt, o_pq_read} !== 2'b00) begin bad++; $display("FAIL reset_pulses: got=%b exp=00", {o_pq_wrt, o_pq_read}); end
        total++;
        if (o_count !== 4'd0) begin bad++; $display("FAIL reset_count: got=%0d exp=0", o_count); end
        total++;
        if (cmd_if.o_rsp_data !== 16'd0 || cmd_if.o_rsp_status !== 1'b0 || o_pq_data !== 16'd0) begin
            bad++;
            $display("FAIL reset_data: rsp=%0d st=%b pq=%0d exp=0/0/0", cmd_if.o_rsp_data, cmd_if.o_rsp_status, o_pq_data);
        end
    endtask

    task automatic test_enq();
        int lat; logic [DW-1:0] rd; logic st; int dw; int dr;
        logic [DW-1:0] vals [2];
        vals[0] = 16'd300;
        vals[1] = 16'd700;
        for (int i = 0; i < 2; i++) begin
            do_cmd(OP_ENQ, vals[i], lat, rd, st, dw, dr);
            total++;
            if (lat !== 6) begin bad++; $display("FAIL enq_latency[%0d]: got=%0d exp=6", i, lat); end
            total++;
            if (st !== ST_OK || rd !== 16'd0) begin bad++; $display("FAIL enq_rsp[%0d]: st=%b data=%0d exp=0/0", i, st, rd); end
            total++;
            if (dw !== 1 || dr !== 0) begin bad++; $display("FAIL enq_pulses[%0d]: wrt=%0d read=%0d exp=1/0", i, dw, dr); end
            total++;
            if (last_wrt_data !== vals[i]) begin bad++; $display("FAIL enq_pq_data[%0d]: got=%0d exp=%0d", i, last_wrt_data, vals[i]); end
        end
        total++;
        if (o_count !== 4'd2) begin bad++; $display("FAIL enq_count: got=%0d exp=2", o_count); end
    endtask

    task automatic test_deq();
        int lat; logic [DW-1:0] rd; logic st; int dw; int dr;
        do_cmd(OP_DEQ, 16'd0, lat, rd, st, dw, dr);
        total++;
        if (lat !== 4) begin bad++; $display("FAIL deq_latency: got=%0d exp=4", lat); end
        total++;
        if (st !== ST_OK || rd !== 16'd700) begin bad++; $display("FAIL deq_rsp: st=%b data=%0d exp=0/700", st, rd); end
        total++;
        if (dw !== 0 || dr !== 1) begin bad++; $display("FAIL deq_pulses: wrt=%0d read=%0d exp=0/1", dw, dr); end
        total++;
        if (o_count !== 4'd1) begin bad++; $display("FAIL deq_count: got=%0d exp=1", o_count); end
    endtask

    task automatic test_full();
        int lat; logic [DW-1:0] rd; logic st; int dw; int dr;
        logic [DW-1:0] exp_d;
        for (int v = 1; v <= 14; v++) do_cmd(OP_ENQ, 16'(v), lat, rd, st, dw, dr);
        total++;
        if (o_count !== 4'd15) begin bad++; $display("FAIL full_count: got=%0d exp=15", o_count); end
        do_cmd(OP_ENQ, 16'd5, lat, rd, st, dw, dr);
        total++;
        if (lat !== 1) begin bad++; $display("FAIL full_reject_latency: got=%0d exp=1", lat); end
        total++;
        if (st !== ST_REJECT || rd !== 16'd0) begin bad++; $display("FAIL full_reject_rsp: st=%b data=%0d exp=1/0", st, rd); end
        total++;
        if (dw !== 0 || dr !== 0) begin bad++; $display("FAIL full_reject_pulses: wrt=%0d read=%0d exp=0/0", dw, dr); end
        total++;
        if (o_count !== 4'd15) begin bad++; $display("FAIL full_reject_count: got=%0d exp=15", o_count); end
        // Drain: 300 first, then 14 down to 1.
        for (int i = 0; i < 15; i++) begin
            exp_d = (i == 0) ? 16'd300 : 16'(15 - i);
            do_cmd(OP_DEQ, 16'd0, lat, rd, st, dw, dr);
            total++;
            if (rd !== exp_d || st !== ST_OK) begin bad++; $display("FAIL drain_data[%0d]: got=%0d st=%b exp=%0d/0", i, rd, st, exp_d); end
        end
        total++;
        if (o_count !== 4'd0) begin bad++; $display("FAIL drain_count: got=%0d exp=0", o_count); end
    endtask

    task automatic test_empty();
        int lat; logic [DW-1:0] rd; logic st; int dw; int dr;
        do_cmd(OP_DEQ, 16'd0, lat, rd, st, dw, dr);
        total++;
        if (lat !== 1 || st !== ST_REJECT || rd !== 16'd0 || dr !== 0) begin
            bad++;
            $display("FAIL empty_deq: lat=%0d st=%b data=%0d reads=%0d exp=1/1/0/0", lat, st, rd, dr);
        end
        do_cmd(OP_REP, 16'd42, lat, rd, st, dw, dr);
        total++;
        if (lat !== 4 || st !== ST_OK || rd !== 16'd0) begin bad++; $display("FAIL rep_empty: lat=%0d st=%b data=%0d exp=4/0/0", lat, st, rd); end
        total++;
        if (dw !== 1 || dr !== 1 || o_count !== 4'd1) begin
            bad++;
            $display("FAIL rep_empty_side: wrt=%0d read=%0d count=%0d exp=1/1/1", dw, dr, o_count);
        end
        do_cmd(OP_REP, 16'd50, lat, rd, st, dw, dr);
        total++;
        if (rd !== 16'd42 || st !== ST_OK || o_count !== 4'd1) begin
            bad++;
            $display("FAIL rep_nonempty: data=%0d st=%b count=%0d exp=42/0/1", rd, st, o_count);
        end
        do_cmd(2'd3, 16'd1, lat, rd, st, dw, dr);
        total++;
        if (lat !== 1 || st !== ST_REJECT || dw !== 0 || dr !== 0 || o_count !== 4'd1) begin
            bad++;
            $display("FAIL illegal_op: lat=%0d st=%b wrt=%0d read=%0d count=%0d exp=1/1/0/0/1", lat, st, dw, dr, o_count);
        end
        do_cmd(OP_DEQ, 16'd0, lat, rd, st, dw, dr);
        total++;
        if (rd !== 16'd50 || o_count !== 4'd0) begin bad++; $display("FAIL rep_then_deq: data=%0d count=%0d exp=50/0", rd, o_count); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [DW-1:0] rd; logic st; int dw; int dr;
        int unstable;
        drive_cmd(OP_ENQ, 16'd9);
        wait_rsp(lat);
        // Next command waits behind the held response.
        @(negedge i_CLK);
        cmd_if.i_cmd_valid = 1'b1;
        cmd_if.i_cmd_op    = OP_DEQ;
        cmd_if.i_cmd_data  = 16'd0;
        unstable = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge i_CLK);
            #1;
            if (cmd_if.o_rsp_valid !== 1'b1 || cmd_if.o_rsp_data !== 16'd0 ||
                cmd_if.o_rsp_status !== ST_OK || cmd_if.o_cmd_ready !== 1'b0) unstable++;
        end
        total++;
        if (unstable !== 0) begin bad++; $display("FAIL hold_stable: unstable_cycles=%0d exp=0", unstable); end
        total++;
        if (o_count !== 4'd1 || read_cnt === 0) begin end
        if (o_count !== 4'd1) begin bad++; $display("FAIL hold_count: got=%0d exp=1", o_count); end
        ack_rsp();
        total++;
        if (cmd_if.o_cmd_ready !== 1'b1 || cmd_if.o_rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL after_handshake: ready=%b valid=%b exp=1/0", cmd_if.o_cmd_ready, cmd_if.o_rsp_valid);
        end
        @(posedge i_CLK);
        #1;
        cmd_if.i_cmd_valid = 1'b0;
        total++;
        if (cmd_if.o_cmd_ready !== 1'b0) begin bad++; $display("FAIL queued_accept: ready=%b exp=0", cmd_if.o_cmd_ready); end
        wait_rsp(lat);
        rd = cmd_if.o_rsp_data;
        st = cmd_if.o_rsp_status;
        ack_rsp();
        total++;
        if (lat !== 4 || rd !== 16'd9 || st !== ST_OK || o_count !== 4'd0) begin
            bad++;
            $display("FAIL queued_deq: lat=%0d data=%0d st=%b count=%0d exp=4/9/0/0", lat, rd, st, o_count);
        end
        dw = 0; dr = 0;
    endtask

    task automatic test_reset_mid();
        int seen;
        drive_cmd(OP_ENQ, 16'd77);
        @(posedge i_CLK);
        #1;
        total++;
        if (o_count !== 4'd1) begin bad++; $display("FAIL mid_pre_count: got=%0d exp=1", o_count); end
        @(posedge i_CLK);
        #1;
        i_RSTn = 1'b0;
        #1;
        total++;
        if (cmd_if.o_cmd_ready !== 1'b1 || cmd_if.o_rsp_valid !== 1'b0 || o_count !== 4'd0 || o_state !== 2'd0) begin
            bad++;
            $display("FAIL mid_reset: ready=%b valid=%b count=%0d state=%0d exp=1/0/0/0",
                     cmd_if.o_cmd_ready, cmd_if.o_rsp_valid, o_count, o_state);
        end
        repeat (2) @(negedge i_CLK);
        i_RSTn = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge i_CLK);
            #1;
            if (cmd_if.o_rsp_valid || o_pq_wrt) seen++;
        end
        total++;
        if (seen !== 0 || o_count !== 4'd0) begin bad++; $display("FAIL mid_no_rsp: active_cycles=%0d count=%0d exp=0/0", seen, o_count); end
    endtask

    initial begin
        cmd_if.i_cmd_valid = 1'b0;
        cmd_if.i_cmd_op    = 2'd0;
        cmd_if.i_cmd_data  = '0;
        cmd_if.i_rsp_ready = 1'b0;
        i_RSTn = 1'b0;
        repeat (3) @(negedge i_CLK);
        test_reset();
        i_RSTn = 1'b1;
        test_enq();
        test_deq();
        test_full();
        test_empty();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL global_timeout: time=%0t limit=200000", $time);
        $fatal(1);
    end

endmodule
